loadable_updown_counter_bcd: RTL and testbench
==============================================

LOADABLE_UPDOWN_COUNTER_BCD -- requirements
Module: loadable_updown_counter_bcd

Interface
REQ-001 The block SHALL have parameter MODULUS, default 60, giving the count length; legal range 2..100, so the count runs 00..MODULUS-1.
REQ-002 The block SHALL have port clk  input  1  system clock; all state SHALL change only on its rising edge except at reset.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port tick  input  1  count enable; single-cycle pulse from the clock dividers, sampled on the clk rising edge.
REQ-005 The block SHALL have port up_down  input  1  direction; 1 = up, 0 = down.
REQ-006 The block SHALL have port load_en  input  1  synchronous load strobe.
REQ-007 The block SHALL have ports set_value1 and set_value10  input  4 each  BCD units and tens digits to load.
REQ-008 The block SHALL have ports dec1 and dec10  output  4 each  registered BCD units and tens digits of the count.
REQ-009 The block SHALL have port carry_pulse  output  1  registered one-cycle carry (up) or borrow (down) pulse for cascading the next digit pair.
REQ-010 The block SHALL have port zero  output  1  high whenever dec10 = 0 and dec1 = 0.
REQ-011 The block SHALL have port done  output  1  registered terminal flag; its behaviour is set by REQ-025 and REQ-026.

Function
REQ-012 Count value SHALL equal 10*dec10 + dec1 and SHALL always be less than MODULUS.
REQ-013 Priority per edge SHALL be load_en, then tick, then hold.
REQ-014 Load (load_en=1) SHALL take effect on the same edge.
- Valid load (both digits <= 9 and value < MODULUS): the set_value digits SHALL be loaded.
- Illegal load: the count SHALL be loaded as MODULUS-1 in BCD.
- carry_pulse SHALL be 0 on that edge.
REQ-015 An up tick with count < MODULUS-1 SHALL increment in BCD: x9 -> (x+1)0, other values dec1+1.
REQ-016 An up tick at MODULUS-1 SHALL wrap the count to 00 and set carry_pulse = 1 for exactly the following cycle.
REQ-017 A down tick with count > 0 SHALL decrement in BCD: x0 -> (x-1)9, other values dec1-1.
REQ-018 A down tick at 00 SHALL wrap the count to MODULUS-1 and set carry_pulse = 1 for exactly the following cycle, except as REQ-025 states.
REQ-019 carry_pulse SHALL be 0 on every edge without a wrap.
REQ-020 With tick held high, the block SHALL count on every clk edge.
- Back-to-back wraps SHALL each produce a carry_pulse cycle.
REQ-021 A change of up_down SHALL take effect on the first tick sampled after it changes; there is no pipeline latency.
REQ-022 A simultaneous load_en and tick SHALL load only, with no count step and no carry.

Reset
REQ-023 reset_n = 0 SHALL asynchronously force dec1 = 0, dec10 = 0, carry_pulse = 0 and done = 0, so zero = 1.
REQ-024 Reset asserted mid-count SHALL discard the count and any pending carry.
- The first tick or load SHALL be honoured on the first rising edge after reset_n returns to 1.

Configuration
REQ-025 With macro BCD_CNT_STOP_AT_ZERO_EN defined, the block SHALL run in timer mode.
- A down tick taking the count 01 -> 00 SHALL set done = 1.
- A down tick at 00 SHALL hold 00, give no carry_pulse and keep done = 1.
- done SHALL clear on load_en or on any up tick.
REQ-026 With BCD_CNT_STOP_AT_ZERO_EN undefined:
- done SHALL be constant 0.
- A down tick at 00 SHALL wrap per REQ-018.
- No timer-mode logic SHALL be synthesised.

Verification
REQ-027 MODULUS=60, up, tick every cycle from 00 -> count 00..59, then 00 with carry_pulse high for exactly one cycle; repeats every 60 ticks.
REQ-028 MODULUS=60, load 3/1 (31), down, 2 ticks -> 30, then 29, with no carry_pulse.
REQ-029 MODULUS=24, load set_value10=3, set_value1=0 (30, illegal) -> count 23; load digits 0xA/0 (illegal) -> count 23.
REQ-030 load_en and tick both high at count 12, up -> count becomes the set value, carry_pulse 0; reset_n pulsed low mid-count at 45 -> outputs 00, zero=1, done=0 with no clk edge.
REQ-031 Macro undefined, MODULUS=60, count 00, down tick -> 59 with carry_pulse one cycle, done stays 0.
REQ-032 Macro defined, count 02, three down ticks -> 01, 00 with done=1, then 00 held with no carry_pulse; then load 10 -> done=0, count 10.

Source files
------------

// File: rtl/loadable_updown_counter_bcd.sv
// Two-digit BCD up/down counter mod MODULUS with sync load, 1-cycle registered carry/borrow; no backpressure.
// Define BCD_CNT_STOP_AT_ZERO_EN for timer mode: down count stops at 00 and raises done.
module loadable_updown_counter_bcd #(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       up_down,
  input  logic       load_en,
  input  logic [3:0] set_value1,
  input  logic [3:0] set_value10,
  output logic [3:0] dec1,
  output logic [3:0] dec10,
  output logic       carry_pulse,
  output logic       zero,
  output logic       done
);

  localparam int         MAXV  = MODULUS - 1;
  localparam logic [3:0] MAX_T = 4'(MAXV / 10);
  localparam logic [3:0] MAX_U = 4'(MAXV % 10);

  logic [3:0] dec1_q, dec1_d;
  logic [3:0] dec10_q, dec10_d;
  logic       carry_q, carry_d;
  logic [7:0] load_val;
  logic       load_ok;
  logic       at_max;
  logic       at_zero;

  // Digits up to 15 each give at most 165, so 8 bits cannot overflow.
  assign load_val = 8'(set_value10) * 8'd10 + 8'(set_value1);
  assign load_ok  = (set_value1 <= 4'd9) && (set_value10 <= 4'd9) && (load_val < 8'(MODULUS));
  assign at_max   = (dec10_q == MAX_T) && (dec1_q == MAX_U);
  assign at_zero  = (dec10_q == 4'd0) && (dec1_q == 4'd0);

`ifdef BCD_CNT_STOP_AT_ZERO_EN
  logic done_q, done_d;
`endif

  always_comb begin
    dec1_d  = dec1_q;
    dec10_d = dec10_q;
    carry_d = 1'b0;
`ifdef BCD_CNT_STOP_AT_ZERO_EN
    done_d  = done_q;
`endif
    if (load_en) begin
      if (load_ok) begin
        dec1_d  = set_value1;
        dec10_d = set_value10;
      end else begin
        dec1_d  = MAX_U;
        dec10_d = MAX_T;
      end
`ifdef BCD_CNT_STOP_AT_ZERO_EN
      done_d = 1'b0;
`endif
    end else if (tick) begin
      if (up_down) begin
        if (at_max) begin
          dec1_d  = 4'd0;
          dec10_d = 4'd0;
          carry_d = 1'b1;
        end else if (dec1_q == 4'd9) begin
          dec1_d  = 4'd0;
          dec10_d = dec10_q + 4'd1;
        end else begin
          dec1_d = dec1_q + 4'd1;
        end
`ifdef BCD_CNT_STOP_AT_ZERO_EN
        done_d = 1'b0;
`endif
      end else begin
        if (at_zero) begin
`ifdef BCD_CNT_STOP_AT_ZERO_EN
          done_d = 1'b1;
`else
          dec1_d  = MAX_U;
          dec10_d = MAX_T;
          carry_d = 1'b1;
`endif
        end else if (dec1_q == 4'd0) begin
          dec1_d  = 4'd9;
          dec10_d = dec10_q - 4'd1;
        end else begin
          dec1_d = dec1_q - 4'd1;
`ifdef BCD_CNT_STOP_AT_ZERO_EN
          if ((dec10_q == 4'd0) && (dec1_q == 4'd1)) done_d = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec1_q  <= 4'd0;
      dec10_q <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      dec1_q  <= dec1_d;
      dec10_q <= dec10_d;
      carry_q <= carry_d;
    end
  end

`ifdef BCD_CNT_STOP_AT_ZERO_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= done_d;
  end
  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  assign dec1        = dec1_q;
  assign dec10       = dec10_q;
  assign carry_pulse = carry_q;
  assign zero        = at_zero;

endmodule

// File: tb/tb_loadable_updown_counter_bcd.sv
// Bench: three counters (MODULUS 60, 24, 100) on shared stimulus, checked every cycle against an integer model.
module tb_loadable_updown_counter_bcd;

  localparam int MODS [3] = '{60, 24, 100};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick, up_down, load_en;
  logic [3:0] set_value1, set_value10;
  logic [3:0] d1 [3];
  logic [3:0] d10 [3];
  logic       cy_o [3];
  logic       zr_o [3];
  logic       dn_o [3];

  int  cnt [3];
  bit  cy [3];
  bit  dn [3];
  bit  chk_en = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  loadable_updown_counter_bcd #(.MODULUS(60)) u_m60 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .up_down(up_down), .load_en(load_en),
    .set_value1(set_value1), .set_value10(set_value10), .dec1(d1[0]), .dec10(d10[0]),
    .carry_pulse(cy_o[0]), .zero(zr_o[0]), .done(dn_o[0]));

  loadable_updown_counter_bcd #(.MODULUS(24)) u_m24 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .up_down(up_down), .load_en(load_en),
    .set_value1(set_value1), .set_value10(set_value10), .dec1(d1[1]), .dec10(d10[1]),
    .carry_pulse(cy_o[1]), .zero(zr_o[1]), .done(dn_o[1]));

  loadable_updown_counter_bcd #(.MODULUS(100)) u_m100 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .up_down(up_down), .load_en(load_en),
    .set_value1(set_value1), .set_value10(set_value10), .dec1(d1[2]), .dec10(d10[2]),
    .carry_pulse(cy_o[2]), .zero(zr_o[2]), .done(dn_o[2]));

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Model: the count is a plain integer 0..m-1; digits are derived by div/mod.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int m;
      int v;
      m = MODS[i];
      cy[i] = 1'b0;
      if (load_en) begin
        v = 10 * int'(set_value10) + int'(set_value1);
        if (set_value1 <= 9 && set_value10 <= 9 && v < m) cnt[i] = v;
        else cnt[i] = m - 1;
        dn[i] = 1'b0;
      end else if (tick) begin
        if (up_down) begin
          if (cnt[i] == m - 1) begin cnt[i] = 0; cy[i] = 1'b1; end
          else cnt[i] = cnt[i] + 1;
          dn[i] = 1'b0;
        end else if (cnt[i] == 0) begin
`ifdef BCD_CNT_STOP_AT_ZERO_EN
          dn[i] = 1'b1;
`else
          cnt[i] = m - 1;
          cy[i] = 1'b1;
`endif
        end else begin
          cnt[i] = cnt[i] - 1;
`ifdef BCD_CNT_STOP_AT_ZERO_EN
          if (cnt[i] == 0) dn[i] = 1'b1;
`endif
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d dec1", MODS[i]),  int'(d1[i]),   cnt[i] % 10);
        chk($sformatf("m%0d dec10", MODS[i]), int'(d10[i]),  cnt[i] / 10);
        chk($sformatf("m%0d carry", MODS[i]), int'(cy_o[i]), int'(cy[i]));
        chk($sformatf("m%0d zero", MODS[i]),  int'(zr_o[i]), int'(cnt[i] == 0));
        chk($sformatf("m%0d done", MODS[i]),  int'(dn_o[i]), int'(dn[i]));
      end
    end
  end

  task automatic step(input bit l, input bit t, input bit u, input int s10, input int s1);
    load_en = l; tick = t; up_down = u;
    set_value10 = 4'(s10); set_value1 = 4'(s1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // m60 count as a two-digit decimal number read from the DUT.
  function automatic int m60_val();
    return 10 * int'(d10[0]) + int'(d1[0]);
  endfunction

  task automatic reset_now(input string nm);
    #2 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; cy[i] = 1'b0; dn[i] = 1'b0; end
    #1;
    chk({nm, " value"}, m60_val(), 0);
    chk({nm, " zero"},  int'(zr_o[0]), 1);
    chk({nm, " carry"}, int'(cy_o[0]), 0);
    chk({nm, " done"},  int'(dn_o[0]), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 1'b0; up_down = 1'b1; load_en = 1'b0;
    set_value1 = 4'd0; set_value10 = 4'd0;
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; cy[i] = 1'b0; dn[i] = 1'b0; end
    #3;
    chk("por value", m60_val(), 0);
    chk("por zero", int'(zr_o[0]), 1);
    chk("por carry", int'(cy_o[0]), 0);
    chk("por done", int'(dn_o[0]), 0);
    chk_en = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Continuous up count: two full laps of the mod-60 counter.
    for (int k = 1; k <= 120; k++) begin
      step(1'b0, 1'b1, 1'b1, 0, 0);
      if (k == 59)  begin chk("up 59", m60_val(), 59); chk("up 59 carry", int'(cy_o[0]), 0); end
      if (k == 60)  begin chk("wrap 00", m60_val(), 0); chk("wrap carry", int'(cy_o[0]), 1); end
      if (k == 61)  begin chk("after wrap", m60_val(), 1); chk("carry cleared", int'(cy_o[0]), 0); end
      if (k == 120) chk("second wrap carry", int'(cy_o[0]), 1);
    end

    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 0, 0);

    // Load 31, count down through a tens boundary.
    step(1'b1, 1'b0, 1'b0, 3, 1);
    chk("load 31", m60_val(), 31);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("down to 29", m60_val(), 29);
    chk("down no carry", int'(cy_o[0]), 0);
    step(1'b0, 1'b1, 1'b1, 0, 0);
    chk("redirect up 30", m60_val(), 30);
    step(1'b0, 1'b1, 1'b0, 0, 0);

    // Illegal loads saturate to MODULUS-1.
    step(1'b1, 1'b0, 1'b1, 3, 0);
    chk("m24 load 30 illegal", 10 * int'(d10[1]) + int'(d1[1]), 23);
    step(1'b1, 1'b0, 1'b1, 10, 0);
    chk("m24 load A0 illegal", 10 * int'(d10[1]) + int'(d1[1]), 23);
    chk("m60 load A0 illegal", m60_val(), 59);
    step(1'b1, 1'b0, 1'b1, 9, 9);
    chk("m100 load 99", 10 * int'(d10[2]) + int'(d1[2]), 99);
    step(1'b1, 1'b0, 1'b1, 0, 12);
    step(1'b0, 1'b1, 1'b1, 0, 0);

    // Load wins over a simultaneous tick; then reset mid-count.
    step(1'b1, 1'b0, 1'b1, 1, 2);
    step(1'b1, 1'b1, 1'b1, 4, 5);
    chk("load over tick", m60_val(), 45);
    chk("load over tick carry", int'(cy_o[0]), 0);
    reset_now("mid reset");
    step(1'b0, 1'b1, 1'b1, 0, 0);
    chk("first tick after reset", m60_val(), 1);
    reset_now("reset2");

    // Down tick at 00.
    step(1'b0, 1'b1, 1'b0, 0, 0);
`ifdef BCD_CNT_STOP_AT_ZERO_EN
    chk("timer hold 00", m60_val(), 0);
    chk("timer done", int'(dn_o[0]), 1);
`else
    chk("borrow 59", m60_val(), 59);
    chk("borrow carry", int'(cy_o[0]), 1);
    chk("done stays 0", int'(dn_o[0]), 0);
`endif
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // 02 down three ticks, then reload 10.
    step(1'b1, 1'b0, 1'b0, 0, 2);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0);
`ifdef BCD_CNT_STOP_AT_ZERO_EN
      if (k == 2) chk("timer reach 00 done", int'(dn_o[0]), 1);
      if (k == 3) begin chk("timer held", m60_val(), 0); chk("timer no carry", int'(cy_o[0]), 0); end
`else
      if (k == 3) chk("wrap after 00", m60_val(), 59);
`endif
    end
    step(1'b1, 1'b0, 1'b0, 1, 0);
    chk("reload 10", m60_val(), 10);
    chk("reload done", int'(dn_o[0]), 0);

    // Timer done cleared by an up tick; m24 up-wrap.
    step(1'b1, 1'b0, 1'b0, 0, 1);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 0, 0);
    step(1'b1, 1'b0, 1'b1, 2, 3);
    step(1'b0, 1'b1, 1'b1, 0, 0);
    chk("m24 wrap carry", int'(cy_o[1]), 1);
    step(1'b0, 1'b1, 1'b1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
